stage3_lsu: RTL and testbench

Load/store unit for stage 3 of the RISC-V pipeline, directly downstream of the stage-2 ALU. Takes the ALU result as the effective address (or passes it through for non-memory ops), formats store data and byte enables toward the data cache, waits out cache stalls, and returns sign/zero-extended load data with the destination register to writeback. Sequential core is a 4-state FSM with one outstanding request.

---
 rtl/stage3_lsu_pkg.sv | 47 ++++
 rtl/stage3_lsu_load_align.sv | 26 ++
 rtl/stage3_lsu.sv | 134 +++++++++++++
 tb/tb_stage3_lsu.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stage3_lsu_pkg.sv
// Shared constants for the stage-3 load/store unit: FSM encodings, funct3 width codes,
// the latched request record and width/alignment helpers.
package stage3_lsu_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;

  typedef enum logic [1:0] {
    WID_BYTE,
    WID_HALF,
    WID_WORD
  } lsu_width_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] din;
    logic [3:0]  we;
    logic        load;
    logic [2:0]  funct3;
  } lsu_req_t;

  // Undefined codes (011, 110, 111) fall through to word width.
  function automatic lsu_width_e lsu_width(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return WID_BYTE;
      2'b01:   return WID_HALF;
      default: return WID_WORD;
    endcase
  endfunction

  function automatic logic lsu_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    case (lsu_width(funct3))
      WID_HALF: return addr_lo[0];
      WID_WORD: return addr_lo != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/stage3_lsu_load_align.sv
// Load data lane selection and sign/zero extension for the stage-3 LSU.
module lsu_load_align
  import stage3_lsu_pkg::*;
(
  input  logic [31:0] dcache_dout,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = dcache_dout[{addr_lo, 3'b000} +: 8];
    half_sel = addr_lo[1] ? dcache_dout[31:16] : dcache_dout[15:0];
    case (funct3)
      LSU_B:   result = {{24{byte_sel[7]}}, byte_sel};
      LSU_BU:  result = {24'b0, byte_sel};
      LSU_H:   result = {{16{half_sel[15]}}, half_sel};
      LSU_HU:  result = {16'b0, half_sel};
      default: result = dcache_dout;
    endcase
  end

endmodule

// File: rtl/stage3_lsu.sv
// Stage-3 load/store unit: one outstanding data-cache request, 4-state FSM.
// Define LSU_MISALIGN_TRAP_EN to flag misaligned halfword/word accesses instead of issuing them.
module stage3_lsu
  import stage3_lsu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_addr,
  input  logic [31:0] in_wdata,
  input  logic [2:0]  in_funct3,
  input  logic        in_load,
  input  logic        in_store,
  input  logic [4:0]  in_rd,
  output logic [31:0] dcache_addr,
  output logic        dcache_re,
  output logic [3:0]  dcache_we,
  output logic [31:0] dcache_din,
  input  logic [31:0] dcache_dout,
  input  logic        dcache_stall,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_misaligned
);

  logic [1:0]  state;
  lsu_req_t    req;
  logic        accept;
  logic        mem_op;
  logic        misaligned;
  logic [3:0]  fmt_we;
  logic [31:0] fmt_din;
  logic [31:0] load_data;

  assign in_ready = (state == ST_IDLE) || (state == ST_RESP);
  assign accept   = in_valid && in_ready;
  assign mem_op   = in_load || in_store;

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = mem_op && lsu_misaligned(in_funct3, in_addr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    case (lsu_width(in_funct3))
      WID_BYTE: begin
        fmt_din = {4{in_wdata[7:0]}};
        fmt_we  = 4'b0001 << in_addr[1:0];
      end
      WID_HALF: begin
        fmt_din = {2{in_wdata[15:0]}};
        fmt_we  = 4'b0011 << {in_addr[1], 1'b0};
      end
      default: begin
        fmt_din = in_wdata;
        fmt_we  = 4'b1111;
      end
    endcase
  end

  lsu_load_align u_load_align (
    .dcache_dout (dcache_dout),
    .addr_lo     (req.addr[1:0]),
    .funct3      (req.funct3),
    .result      (load_data)
  );

  // Cache-facing outputs come straight from the latched request, so a stall holds them.
  assign dcache_addr = {req.addr[31:2], 2'b00};
  assign dcache_din  = req.din;
  assign dcache_re   = (state == ST_ISSUE) && req.load;
  assign dcache_we   = (state == ST_ISSUE) ? req.we : 4'b0000;
  assign out_valid   = (state == ST_RESP);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state          <= ST_IDLE;
      req            <= '0;
      out_data       <= '0;
      out_rd         <= '0;
      out_misaligned <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_RESP: begin
          if (accept) begin
            out_misaligned <= misaligned;
            if (!mem_op) begin
              out_data <= in_addr;
              out_rd   <= in_rd;
              state    <= ST_RESP;
            end else if (misaligned) begin
              out_data <= '0;
              out_rd   <= in_load ? in_rd : 5'd0;
              state    <= ST_RESP;
            end else begin
              req.addr   <= in_addr;
              req.din    <= fmt_din;
              req.we     <= in_load ? 4'b0000 : fmt_we;
              req.load   <= in_load;
              req.funct3 <= in_funct3;
              out_data   <= '0;
              out_rd     <= in_load ? in_rd : 5'd0;
              state      <= ST_ISSUE;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (!dcache_stall) begin
            if (req.load) begin
              state <= ST_WAIT;
            end else begin
              out_data <= '0;
              out_rd   <= '0;
              state    <= ST_RESP;
            end
          end
        end
        ST_WAIT: begin
          if (!dcache_stall) begin
            out_data <= load_data;
            state    <= ST_RESP;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_stage3_lsu.sv
// Self-checking bench for stage3_lsu: directed cases plus randomized ops against a behavioural model.
module tb_stage3_lsu;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_addr;
  logic [31:0] in_wdata;
  logic [2:0]  in_funct3;
  logic        in_load;
  logic        in_store;
  logic [4:0]  in_rd;
  logic [31:0] dcache_addr;
  logic        dcache_re;
  logic [3:0]  dcache_we;
  logic [31:0] dcache_din;
  logic [31:0] dcache_dout;
  logic        dcache_stall;
  logic        out_valid;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  logic        out_misaligned;

  int errors = 0;
  int checks = 0;

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  stage3_lsu dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_addr        (in_addr),
    .in_wdata       (in_wdata),
    .in_funct3      (in_funct3),
    .in_load        (in_load),
    .in_store       (in_store),
    .in_rd          (in_rd),
    .dcache_addr    (dcache_addr),
    .dcache_re      (dcache_re),
    .dcache_we      (dcache_we),
    .dcache_din     (dcache_din),
    .dcache_dout    (dcache_dout),
    .dcache_stall   (dcache_stall),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_rd         (out_rd),
    .out_misaligned (out_misaligned)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] dout, input logic [31:0] addr,
                                             input logic [2:0] f3);
    int n = nbytes(f3);
    int lane;
    logic [31:0] v;
    if (n == 4) return dout;
    lane = (n == 1) ? int'(addr[1:0]) : 2 * int'(addr[1]);
    v = (dout >> (8 * lane)) & ((32'h1 << (8 * n)) - 32'h1);
    if (!f3[2] && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  function automatic logic [3:0] model_we(input logic [31:0] addr, input logic [2:0] f3);
    int n = nbytes(f3);
    int lane;
    if (n == 4) return 4'b1111;
    lane = (n == 1) ? int'(addr[1:0]) : 2 * int'(addr[1]);
    return 4'((n == 1 ? 1 : 3) << lane);
  endfunction

  function automatic logic [31:0] model_din(input logic [31:0] w, input logic [2:0] f3);
    int n = nbytes(f3);
    if (n == 1) return {4{w[7:0]}};
    if (n == 2) return {2{w[15:0]}};
    return w;
  endfunction

  function automatic bit model_mis(input logic [31:0] addr, input logic [2:0] f3);
    int n = nbytes(f3);
    if (!TRAP) return 1'b0;
    return (addr % n) != 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one op from an idle unit and follow it through to the cycle after its result pulse.
  task automatic run_op(input string tag, input logic ld, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                        input int si, input int sw, input logic [31:0] dout);
    bit mem = ld || st;
    bit mis = mem && model_mis(addr, f3);
    logic [31:0] exp_data;
    logic [4:0]  exp_rd;
    in_valid  = 1'b1;
    in_load   = ld;
    in_store  = st;
    in_funct3 = f3;
    in_addr   = addr;
    in_wdata  = wdata;
    in_rd     = rd;
    check({tag, ".in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    in_addr  = $urandom;
    in_wdata = $urandom;
    if (!mem || mis) begin
      exp_data = mem ? 32'h0 : addr;
      exp_rd   = (mem && !ld) ? 5'd0 : rd;
    end else begin
      for (int k = 0; k <= si; k++) begin
        dcache_stall = (k < si);
        check({tag, ".addr"}, dcache_addr, {addr[31:2], 2'b00});
        check({tag, ".re"}, dcache_re, ld);
        check({tag, ".we"}, dcache_we, ld ? 4'b0000 : model_we(addr, f3));
        if (!ld) check({tag, ".din"}, dcache_din, model_din(wdata, f3));
        check({tag, ".early_valid"}, out_valid, 0);
        step();
      end
      dcache_stall = 1'b0;
      if (ld) begin
        for (int k = 0; k <= sw; k++) begin
          dcache_stall = (k < sw);
          dcache_dout  = (k < sw) ? $urandom : dout;
          check({tag, ".wait_re"}, dcache_re, 0);
          check({tag, ".wait_valid"}, out_valid, 0);
          step();
        end
        exp_data = model_load(dout, addr, f3);
        exp_rd   = rd;
      end else begin
        exp_data = 32'h0;
        exp_rd   = 5'd0;
      end
    end
    dcache_stall = 1'b0;
    check({tag, ".valid"}, out_valid, 1);
    check({tag, ".data"}, out_data, exp_data);
    check({tag, ".rd"}, out_rd, exp_rd);
    check({tag, ".mis"}, out_misaligned, mis);
    check({tag, ".resp_re"}, dcache_re, 0);
    check({tag, ".resp_we"}, dcache_we, 0);
    step();
    check({tag, ".pulse_end"}, out_valid, 0);
  endtask

  initial begin
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_addr      = '0;
    in_wdata     = '0;
    in_funct3    = '0;
    in_load      = 1'b0;
    in_store     = 1'b0;
    in_rd        = '0;
    dcache_dout  = '0;
    dcache_stall = 1'b0;
    step();
    step();
    check("rst.in_ready", in_ready, 1);
    check("rst.out_valid", out_valid, 0);
    check("rst.re", dcache_re, 0);
    check("rst.we", dcache_we, 0);
    check("rst.data", out_data, 0);
    check("rst.rd", out_rd, 0);
    check("rst.mis", out_misaligned, 0);
    reset_n = 1'b1;
    step();

    run_op("sb", 1'b0, 1'b1, 3'b000, 32'h1003, 32'h0000_00A5, 5'd9, 0, 0, 32'h0);
    run_op("lb", 1'b1, 1'b0, 3'b000, 32'h2002, 32'h0, 5'd3, 0, 0, 32'h12F4_5678);
    run_op("lbu", 1'b1, 1'b0, 3'b100, 32'h2002, 32'h0, 5'd4, 0, 0, 32'h12F4_5678);
    run_op("lw_stall", 1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 5'd7, 3, 2, 32'hCAFE_F00D);
    run_op("lh_odd", 1'b1, 1'b0, 3'b001, 32'h4001, 32'h0, 5'd8, 0, 0, 32'h1234_ABCD);
    run_op("sh_hi", 1'b0, 1'b1, 3'b001, 32'h5002, 32'h0000_BEEF, 5'd2, 1, 0, 32'h0);

    // Back-to-back non-memory ops accepted in RESP.
    in_valid = 1'b1; in_load = 1'b0; in_store = 1'b0;
    in_addr = 32'hDEAD_BEEF; in_rd = 5'd5;
    step();
    check("b2b.valid0", out_valid, 1);
    check("b2b.data0", out_data, 32'hDEAD_BEEF);
    check("b2b.rd0", out_rd, 5);
    check("b2b.ready0", in_ready, 1);
    in_addr = 32'h1; in_rd = 5'd6;
    step();
    in_valid = 1'b0;
    check("b2b.valid1", out_valid, 1);
    check("b2b.data1", out_data, 32'h1);
    check("b2b.rd1", out_rd, 6);
    check("b2b.ready1", in_ready, 1);
    step();
    check("b2b.idle", out_valid, 0);

    // Reset while a load sits in WAIT.
    in_valid = 1'b1; in_load = 1'b1; in_store = 1'b0; in_funct3 = 3'b010;
    in_addr = 32'h6000; in_rd = 5'd11;
    step();
    in_valid = 1'b0;
    check("rstw.issue_re", dcache_re, 1);
    step();
    dcache_stall = 1'b1;
    check("rstw.wait_re", dcache_re, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    dcache_stall = 1'b0;
    check("rstw.re", dcache_re, 0);
    check("rstw.valid", out_valid, 0);
    check("rstw.ready", in_ready, 1);
    check("rstw.data", out_data, 0);
    for (int k = 0; k < 4; k++) begin
      step();
      check("rstw.no_late", out_valid, 0);
    end

    for (int i = 0; i < 300; i++) begin
      logic [1:0] cls = 2'($urandom_range(0, 3));
      run_op("rnd", cls[0], cls[1], 3'($urandom_range(0, 7)), $urandom, $urandom,
             5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
